// File: rtl/sr_latch_driver.sv
// sr_latch_driver: masked write to a gated SR latch bank as pulse, settle, readback check; SR_LATCH_DRV_RETRY_EN adds one retry
module sr_latch_driver #(
  parameter int WIDTH = 8,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             en_n,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, DRIVE, GAP, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] data, mask, data_nx, mask_nx;
  logic [7:0] cnt, cnt_nx;
  logic err_nx, mism;
`ifdef SR_LATCH_DRV_RETRY_EN
  logic retried, retried_nx;
`endif
  assign wr_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign mism = |((q_in ^ data) & mask);
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    data_nx = data;
    mask_nx = mask;
    err_nx = err;
`ifdef SR_LATCH_DRV_RETRY_EN
    retried_nx = retried;
`endif
    case (state)
      IDLE: if (wr_valid) begin
        data_nx = wr_data;
        mask_nx = wr_mask;
        cnt_nx = 8'(PULSE_CYC - 1);
        state_nx = |wr_mask ? DRIVE : DONE;
        err_nx = 1'b0;
`ifdef SR_LATCH_DRV_RETRY_EN
        retried_nx = 1'b0;
`endif
      end
      DRIVE: begin
        cnt_nx = cnt == '0 ? 8'(GAP_CYC - 1) : cnt - 8'd1;
        state_nx = cnt == '0 ? GAP : DRIVE;
      end
      GAP: begin
        cnt_nx = cnt == '0 ? '0 : cnt - 8'd1;
        state_nx = cnt == '0 ? CHECK : GAP;
      end
      CHECK: begin
`ifdef SR_LATCH_DRV_RETRY_EN
        if (mism && !retried) begin
          retried_nx = 1'b1;
          cnt_nx = 8'(PULSE_CYC - 1);
          state_nx = DRIVE;
        end else begin
          err_nx = mism;
          state_nx = DONE;
        end
`else
        err_nx = mism;
        state_nx = DONE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end
  // S/R derive from the next state so latch lines and gate move on the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      data <= '0;
      mask <= '0;
      err <= 1'b0;
      s_out <= '0;
      r_out <= '0;
      en_n <= 1'b1;
`ifdef SR_LATCH_DRV_RETRY_EN
      retried <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      data <= data_nx;
      mask <= mask_nx;
      err <= err_nx;
      s_out <= state_nx == DRIVE ? mask_nx & data_nx : '0;
      r_out <= state_nx == DRIVE ? mask_nx & ~data_nx : '0;
      en_n <= state_nx != DRIVE;
`ifdef SR_LATCH_DRV_RETRY_EN
      retried <= retried_nx;
`endif
    end
  end
endmodule
